// File: rtl/calc_pkg.sv
// calc_pkg: opcode constants, sequencer state encoding and operand limits shared by the calculator blocks
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_A     = 3'd1,
        GET_B     = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;

    localparam int unsigned OP_MAX_DEF  = 4;
    localparam int unsigned VAL_MAX_DEF = 999;

    function automatic logic is_unary(input logic [2:0] op);
        return op == OP_NOT;
    endfunction

endpackage

// File: rtl/calc_cmd_sequencer_if.sv
// calc_cmd_sequencer_if: operand/opcode launch and result return between sequencer (master) and ALU (slave)
interface calc_cmd_sequencer_if;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;

    modport master (output alu_op, alu_a, alu_b, alu_start, input alu_done, alu_result);
    modport slave  (input alu_op, alu_a, alu_b, alu_start, output alu_done, alu_result);
endinterface

// File: rtl/calc_cmd_timeout.sv
// calc_cmd_timeout: idle counter between operands, flags expiry after TIMEOUT_CYC waiting cycles
module calc_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYC = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic num_valid,
    output logic expire
);
    localparam int unsigned W = $clog2(TIMEOUT_CYC);

    logic [W-1:0] cnt;

    assign expire = waiting && !num_valid && cnt == W'(TIMEOUT_CYC - 1);

    // count waiting cycles; any operand, leaving the wait states or expiry restarts from zero
    always_ff @(posedge clk) begin
        if (rst || num_valid || !waiting || expire)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: collects opcode and operands from the parser, launches the ALU, returns its result
// Optional feature: define CALC_CMD_TIMEOUT_EN to abort an operation stalled in GET_A/GET_B.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 100000000,
    parameter int unsigned OP_MAX      = OP_MAX_DEF,
    parameter int unsigned VAL_MAX     = VAL_MAX_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 num_in,
    input  logic                        num_valid,
    calc_cmd_sequencer_if.master        alu,
    output logic [15:0]                 res_out,
    output logic                        res_valid,
    output logic                        err,
    output logic [2:0]                  state_dbg
);
    if (TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_t state, next;
    logic   err_d, ld_op, ld_a, ld_b, clr_b, cap, expire;
    logic   waiting;

    assign state_dbg = state;
    assign waiting   = state == GET_A || state == GET_B;

`ifdef CALC_CMD_TIMEOUT_EN
    calc_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .waiting   (waiting),
        .num_valid (num_valid),
        .expire    (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // next state, register load enables and error decision
    always_comb begin
        next  = state;
        err_d = 1'b0;
        ld_op = 1'b0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        clr_b = 1'b0;
        cap   = 1'b0;
        case (state)
            IDLE: begin
                if (num_valid) begin
                    ld_op = num_in <= 16'(OP_MAX);
                    err_d = !ld_op;
                    next  = ld_op ? GET_A : IDLE;
                end
            end
            GET_A: begin
                if (num_valid) begin
                    ld_a  = num_in <= 16'(VAL_MAX);
                    clr_b = ld_a && is_unary(alu.alu_op);
                    err_d = !ld_a;
                    next  = !ld_a ? IDLE : clr_b ? ISSUE : GET_B;
                end else if (expire) begin
                    err_d = 1'b1;
                    next  = IDLE;
                end
            end
            GET_B: begin
                if (num_valid) begin
                    ld_b  = num_in <= 16'(VAL_MAX);
                    err_d = !ld_b;
                    next  = ld_b ? ISSUE : IDLE;
                end else if (expire) begin
                    err_d = 1'b1;
                    next  = IDLE;
                end
            end
            ISSUE: begin
                err_d = num_valid;
                next  = WAIT_DONE;
            end
            WAIT_DONE: begin
                err_d = num_valid;
                cap   = alu.alu_done;
                next  = alu.alu_done ? IDLE : WAIT_DONE;
            end
            default: next = IDLE;
        endcase
    end

    // state, operand/result registers and single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            alu.alu_op    <= '0;
            alu.alu_a     <= '0;
            alu.alu_b     <= '0;
            alu.alu_start <= 1'b0;
            res_out       <= '0;
            res_valid     <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= next;
            alu.alu_start <= next == ISSUE;
            res_valid     <= cap;
            err           <= err_d;
            if (ld_op) alu.alu_op <= num_in[2:0];
            if (ld_a) alu.alu_a <= num_in;
            if (ld_b) alu.alu_b <= num_in;
            else if (clr_b) alu.alu_b <= '0;
            if (cap) res_out <= alu.alu_result;
        end
    end
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb_calc_cmd_sequencer: directed self-checking bench for calc_cmd_sequencer
module tb_calc_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] num_in = '0;
    logic        num_valid = 1'b0;
    logic [15:0] res_out;
    logic        res_valid, err;
    logic [2:0]  state_dbg;
    int          errors = 0;
    int          checks = 0;
    int          n_start = 0, n_rv = 0, n_err = 0, dbl = 0;
    logic        p_start = 1'b0, p_rv = 1'b0, p_err = 1'b0, seen_getb = 1'b0;

    calc_cmd_sequencer_if alu_if();

    calc_cmd_sequencer #(.TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .num_in    (num_in),
        .num_valid (num_valid),
        .alu       (alu_if.master),
        .res_out   (res_out),
        .res_valid (res_valid),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_start += int'(alu_if.alu_start);
        n_rv    += int'(res_valid);
        n_err   += int'(err);
        if ((alu_if.alu_start && p_start) || (res_valid && p_rv) || (err && p_err)) dbl++;
        if (state_dbg == 3'd2) seen_getb = 1'b1;
        p_start = alu_if.alu_start;
        p_rv    = res_valid;
        p_err   = err;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v);
        num_in = v;
        num_valid = 1'b1;
        tick();
        num_valid = 1'b0;
    endtask

    task automatic done(input logic [15:0] r);
        alu_if.alu_done = 1'b1;
        alu_if.alu_result = r;
        tick();
        alu_if.alu_done = 1'b0;
    endtask

    task automatic clear_counts();
        n_start = 0;
        n_rv = 0;
        n_err = 0;
        seen_getb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({alu_if.alu_op, alu_if.alu_a, alu_if.alu_b, res_out} !== 51'd0) begin
            errors++;
            $display("FAIL reset_regs: op=%0d a=%0d b=%0d res=%0d, want all 0", alu_if.alu_op, alu_if.alu_a, alu_if.alu_b, res_out);
        end
        checks++;
        if ({alu_if.alu_start, res_valid, err, state_dbg} !== 6'd0) begin
            errors++;
            $display("FAIL reset_ctrl: start=%0b rv=%0b err=%0b state=%0d, want 0 0 0 0", alu_if.alu_start, res_valid, err, state_dbg);
        end
    endtask

    task automatic test_binary();
        clear_counts();
        strobe(16'd0);
        checks++;
        if (state_dbg !== 3'd1) begin errors++; $display("FAIL bin_get_a: state=%0d want 1", state_dbg); end
        strobe(16'd12);
        checks++;
        if ({state_dbg, alu_if.alu_a} !== {3'd2, 16'd12}) begin
            errors++; $display("FAIL bin_get_b: state=%0d a=%0d want 2 12", state_dbg, alu_if.alu_a);
        end
        strobe(16'd30);
        checks++;
        if ({state_dbg, alu_if.alu_start, alu_if.alu_op, alu_if.alu_b} !== {3'd3, 1'b1, 3'd0, 16'd30}) begin
            errors++; $display("FAIL bin_issue: state=%0d start=%0b op=%0d b=%0d want 3 1 0 30", state_dbg, alu_if.alu_start, alu_if.alu_op, alu_if.alu_b);
        end
        tick();
        checks++;
        if ({state_dbg, alu_if.alu_start} !== {3'd4, 1'b0}) begin
            errors++; $display("FAIL bin_wait: state=%0d start=%0b want 4 0", state_dbg, alu_if.alu_start);
        end
        tick();
        tick();
        done(16'd42);
        checks++;
        if ({res_out, res_valid, state_dbg} !== {16'd42, 1'b1, 3'd0}) begin
            errors++; $display("FAIL bin_result: res=%0d rv=%0b state=%0d want 42 1 0", res_out, res_valid, state_dbg);
        end
        tick();
        checks++;
        if ({res_valid, res_out} !== {1'b0, 16'd42}) begin
            errors++; $display("FAIL bin_hold: rv=%0b res=%0d want 0 42", res_valid, res_out);
        end
        checks++;
        if (n_start !== 1 || n_rv !== 1 || n_err !== 0) begin
            errors++; $display("FAIL bin_pulses: start=%0d rv=%0d err=%0d want 1 1 0", n_start, n_rv, n_err);
        end
    endtask

    task automatic test_unary();
        clear_counts();
        strobe(16'd4);
        strobe(16'd7);
        checks++;
        if ({state_dbg, alu_if.alu_start, alu_if.alu_op, alu_if.alu_a, alu_if.alu_b} !== {3'd3, 1'b1, 3'd4, 16'd7, 16'd0}) begin
            errors++; $display("FAIL unary_issue: state=%0d start=%0b op=%0d a=%0d b=%0d want 3 1 4 7 0", state_dbg, alu_if.alu_start, alu_if.alu_op, alu_if.alu_a, alu_if.alu_b);
        end
        tick();
        done(16'hFFF8);
        checks++;
        if ({res_out, res_valid, seen_getb} !== {16'hFFF8, 1'b1, 1'b0}) begin
            errors++; $display("FAIL unary_result: res=%0h rv=%0b getb=%0b want fff8 1 0", res_out, res_valid, seen_getb);
        end
        tick();
    endtask

    task automatic test_errors();
        clear_counts();
        strobe(16'd9);
        checks++;
        if ({err, state_dbg} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL bad_op: err=%0b state=%0d want 1 0", err, state_dbg);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL bad_op_pulse: err=%0b want 0", err); end
        strobe(16'd1);
        strobe(16'd1000);
        checks++;
        if ({err, state_dbg} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL bad_a: err=%0b state=%0d want 1 0", err, state_dbg);
        end
        strobe(16'd3);
        strobe(16'd999);
        checks++;
        if ({state_dbg, alu_if.alu_a} !== {3'd2, 16'd999}) begin
            errors++; $display("FAIL max_a: state=%0d a=%0d want 2 999", state_dbg, alu_if.alu_a);
        end
        strobe(16'd1000);
        checks++;
        if ({err, state_dbg} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL bad_b: err=%0b state=%0d want 1 0", err, state_dbg);
        end
        tick();
        checks++;
        if (n_start !== 0 || n_err !== 3) begin
            errors++; $display("FAIL err_pulses: start=%0d err=%0d want 0 3", n_start, n_err);
        end
    endtask

    task automatic test_overrun();
        clear_counts();
        strobe(16'd1);
        strobe(16'd100);
        strobe(16'd50);
        tick();
        strobe(16'd7);
        checks++;
        if ({err, state_dbg, alu_if.alu_a, alu_if.alu_b} !== {1'b1, 3'd4, 16'd100, 16'd50}) begin
            errors++; $display("FAIL overrun: err=%0b state=%0d a=%0d b=%0d want 1 4 100 50", err, state_dbg, alu_if.alu_a, alu_if.alu_b);
        end
        done(16'd50);
        checks++;
        if ({res_valid, res_out, err} !== {1'b1, 16'd50, 1'b0}) begin
            errors++; $display("FAIL overrun_result: rv=%0b res=%0d err=%0b want 1 50 0", res_valid, res_out, err);
        end
        strobe(16'd3);
        strobe(16'd6);
        strobe(16'd5);
        tick();
        alu_if.alu_result = 16'd4;
        alu_if.alu_done = 1'b1;
        num_in = 16'd8;
        num_valid = 1'b1;
        tick();
        alu_if.alu_done = 1'b0;
        num_valid = 1'b0;
        checks++;
        if ({err, res_valid, res_out, state_dbg, alu_if.alu_a} !== {1'b1, 1'b1, 16'd4, 3'd0, 16'd6}) begin
            errors++; $display("FAIL done_and_num: err=%0b rv=%0b res=%0d state=%0d a=%0d want 1 1 4 0 6", err, res_valid, res_out, state_dbg, alu_if.alu_a);
        end
        tick();
        done(16'd77);
        checks++;
        if ({res_valid, err, res_out, state_dbg} !== {1'b0, 1'b0, 16'd4, 3'd0}) begin
            errors++; $display("FAIL stray_done: rv=%0b err=%0b res=%0d state=%0d want 0 0 4 0", res_valid, err, res_out, state_dbg);
        end
    endtask

    task automatic test_reset_mid();
        strobe(16'd2);
        strobe(16'd5);
        strobe(16'd6);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({state_dbg, alu_if.alu_op, alu_if.alu_a, alu_if.alu_b, res_out, alu_if.alu_start, res_valid, err} !== 57'd0) begin
            errors++; $display("FAIL reset_mid: state=%0d op=%0d a=%0d b=%0d res=%0d want all 0", state_dbg, alu_if.alu_op, alu_if.alu_a, alu_if.alu_b, res_out);
        end
        clear_counts();
        done(16'd99);
        tick();
        checks++;
        if ({res_out, state_dbg} !== {16'd0, 3'd0} || n_rv !== 0 || n_err !== 0) begin
            errors++; $display("FAIL late_done: res=%0d state=%0d rv_pulses=%0d err_pulses=%0d want 0 0 0 0", res_out, state_dbg, n_rv, n_err);
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        strobe(16'd2);
`ifdef CALC_CMD_TIMEOUT_EN
        repeat (15) tick();
        checks++;
        if ({state_dbg, err} !== {3'd1, 1'b0}) begin
            errors++; $display("FAIL timeout_early: state=%0d err=%0b want 1 0", state_dbg, err);
        end
        tick();
        checks++;
        if ({state_dbg, err} !== {3'd0, 1'b1}) begin
            errors++; $display("FAIL timeout_fire: state=%0d err=%0b want 0 1", state_dbg, err);
        end
        tick();
        checks++;
        if (err !== 1'b0 || n_err !== 1) begin
            errors++; $display("FAIL timeout_pulse: err=%0b pulses=%0d want 0 1", err, n_err);
        end
`else
        repeat (40) tick();
        checks++;
        if ({state_dbg, err} !== {3'd1, 1'b0} || n_err !== 0) begin
            errors++; $display("FAIL no_timeout: state=%0d err_pulses=%0d want 1 0", state_dbg, n_err);
        end
        strobe(16'd3);
        strobe(16'd4);
        tick();
        done(16'd12);
        checks++;
        if ({res_out, res_valid} !== {16'd12, 1'b1}) begin
            errors++; $display("FAIL no_timeout_result: res=%0d rv=%0b want 12 1", res_out, res_valid);
        end
        tick();
`endif
    endtask

    initial begin
        alu_if.alu_done = 1'b0;
        alu_if.alu_result = '0;
        test_reset();
        test_binary();
        test_unary();
        test_errors();
        test_overrun();
        test_reset_mid();
        test_timeout();
        checks++;
        if (dbl !== 0) begin errors++; $display("FAIL pulse_width: consecutive pulses=%0d want 0", dbl); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calc_cmd_sequencer.md
CALC_CMD_SEQUENCER -- requirements
Module: calc_cmd_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 100000000: idle cycles allowed between operands before abort (used only with CALC_CMD_TIMEOUT_EN).
REQ-002 Parameter OP_MAX, default 4: highest legal opcode value.
REQ-003 Parameter VAL_MAX, default 999: highest legal operand value.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 num_in  input  16  parsed decimal number from the command parser.
REQ-007 num_valid  input  1  single-cycle strobe; num_in valid this cycle.
REQ-008 alu_op  output  3  registered opcode presented to the ALU.
REQ-009 alu_a  output  16  registered operand A.
REQ-010 alu_b  output  16  registered operand B; 0 for unary ops.
REQ-011 alu_start  output  1  single-cycle pulse launching the ALU.
REQ-012 alu_done  input  1  single-cycle ALU completion strobe.
REQ-013 alu_result  input  16  ALU result; valid when alu_done=1.
REQ-014 res_out  output  16  last captured result; holds until next capture.
REQ-015 res_valid  output  1  single-cycle pulse; new res_out.
REQ-016 err  output  1  single-cycle error pulse.
REQ-017 state_dbg  output  3  current state encoding.

Function
REQ-018 States: IDLE, GET_A, GET_B, ISSUE, WAIT_DONE.
REQ-019 Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 NOT (unary); NOT is the only unary op.
REQ-020 IDLE + num_valid: num_in<=OP_MAX -> latch alu_op[2:0], go GET_A; else err pulse, stay IDLE.
REQ-021 GET_A + num_valid: num_in<=VAL_MAX -> latch alu_a; unary -> alu_b=0, go ISSUE; binary -> go GET_B. num_in>VAL_MAX -> err, go IDLE.
REQ-022 GET_B + num_valid: num_in<=VAL_MAX -> latch alu_b, go ISSUE; else err, go IDLE.
REQ-023 ISSUE: alu_start=1 for exactly one cycle (cycle after the final operand strobe), unconditional go WAIT_DONE.
REQ-024 WAIT_DONE + alu_done: res_out<=alu_result, res_valid=1 next cycle, go IDLE.
REQ-025 num_valid in ISSUE or WAIT_DONE: number dropped, err pulse (overrun), state unchanged.
REQ-026 alu_done outside WAIT_DONE: ignored, no err.
REQ-027 alu_done and num_valid in the same WAIT_DONE cycle: result captured, number dropped, err pulse.
REQ-028 err, res_valid, alu_start never asserted for more than one consecutive cycle each.

Reset
REQ-029 rst=1 in any state, including WAIT_DONE mid-operation: state=IDLE next edge; pending op discarded.
REQ-030 Reset values: alu_op=0, alu_a=0, alu_b=0, res_out=0, alu_start=0, res_valid=0, err=0, state_dbg=IDLE, timeout counter=0.
REQ-031 alu_done arriving after reset from an aborted op: ignored per REQ-026.

Configuration
REQ-032 Macro CALC_CMD_TIMEOUT_EN defined: counter increments each cycle in GET_A/GET_B, clears on num_valid or state change; reaching TIMEOUT_CYC-1 -> err pulse, go IDLE.
REQ-033 Macro CALC_CMD_TIMEOUT_EN undefined: no counter hardware; GET_A/GET_B wait indefinitely.

Structure
REQ-034 Shared package calc_pkg: opcode constants, state encoding, VAL_MAX default; reused by ALU and display logic.
REQ-035 Sub-module calc_cmd_timeout (counter plus expiry compare), instantiated only under CALC_CMD_TIMEOUT_EN.

Verification
REQ-036 Numbers 0, 12, 30; alu_done with result 42 three cycles after alu_start -> alu_op=0, a=12, b=30, one alu_start pulse, res_out=42 with one res_valid pulse.
REQ-037 Numbers 4, 7 -> alu_b=0, alu_start the cycle after the second strobe, no GET_B visit.
REQ-038 Number 9 in IDLE -> err pulse, stays IDLE; then 1, 1000 -> err, returns IDLE, no alu_start.
REQ-039 Number during WAIT_DONE -> err pulse, alu_a/alu_b unchanged, subsequent alu_done still yields res_valid.
REQ-040 rst asserted in WAIT_DONE, then alu_done -> no res_valid, all outputs at reset values.
REQ-041 CALC_CMD_TIMEOUT_EN, TIMEOUT_CYC=16: opcode 2 then silence -> err after 16 cycles in GET_A, state IDLE.
